// File: rtl/seq_detect_scheduler.sv
// Front-end scheduler for an external 010110 sequence detector: serialises a word
// MSB-first, drives the detector mode/clear lines, and gathers the match map and count.
module seq_detect_scheduler #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_mode,
    output logic              det_reset,
    output logic              det_x,
    output logic              det_m,
    input  logic              det_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [WORD_W-1:0] match_map,
    output logic              busy
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [WORD_W-1:0]   word_reg, word_next;
    logic                mode_reg, mode_next;
    logic                det_reset_reg, det_reset_next;
    logic                det_x_reg, det_x_next;
    logic                det_m_reg, det_m_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [WORD_W-1:0]   map_reg, map_next;

    logic                credit_en;
    logic [IDX_W-1:0]    credit_k;
    logic [IDX_W-1:0]    credit_pos;
    logic                credit_hit;
    logic                clear_res;
    logic [WORD_W-1:0]   hit_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            word_reg      <= '0;
            mode_reg      <= 1'b0;
            det_reset_reg <= 1'b0;
            det_x_reg     <= 1'b0;
            det_m_reg     <= 1'b0;
            cnt_reg       <= '0;
            map_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            word_reg      <= word_next;
            mode_reg      <= mode_next;
            det_reset_reg <= det_reset_next;
            det_x_reg     <= det_x_next;
            det_m_reg     <= det_m_next;
            cnt_reg       <= cnt_next;
            map_reg       <= map_next;
        end
    end

    // word_reg is consumed as a shift register: its MSB is always the next stream bit.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        word_next      = word_reg;
        mode_next      = mode_reg;
        det_reset_next = 1'b0;
        det_x_next     = 1'b0;
        det_m_next     = det_m_reg;
        credit_en      = 1'b0;
        credit_k       = idx_reg;
        clear_res      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next     = ST_CLR;
                    word_next      = in_word;
                    mode_next      = in_mode;
                    det_reset_next = 1'b1;
                    det_m_next     = in_mode;
                end
            end
            ST_CLR: begin
                state_next = ST_SHIFT;
                idx_next   = '0;
                clear_res  = 1'b1;
                det_x_next = word_reg[WORD_W-1];
                word_next  = word_reg << 1;
            end
            ST_SHIFT: begin
                // Moore output lags the input by one clock, so its credit trails by one bit.
                credit_en = mode_reg | (idx_reg != '0);
                credit_k  = mode_reg ? idx_reg : idx_reg - 1'b1;
                if (idx_reg == IDX_LAST) begin
                    state_next = mode_reg ? ST_DONE : ST_DRAIN;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    det_x_next = word_reg[WORD_W-1];
                    word_next  = word_reg << 1;
                end
            end
            ST_DRAIN: begin
                credit_en  = 1'b1;
                credit_k   = IDX_LAST;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign credit_hit = credit_en & det_z;
    assign credit_pos = IDX_LAST - credit_k;

    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_hit
            assign hit_vec[gi] = credit_hit && (credit_pos == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        map_next = map_reg | hit_vec;
        cnt_next = cnt_reg;
        if (credit_hit && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
        if (clear_res) begin
            map_next = '0;
            cnt_next = '0;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign det_reset = det_reset_reg;
    assign det_x     = det_x_reg;
    assign det_m     = det_m_reg;
    assign match_cnt = cnt_reg;
    assign match_map = map_reg;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: a window-based 010110 detector drives det_z, and a
// cycle-timeline model plus a word-scan model check every output every cycle.
module tb_seq_detect_scheduler;
    localparam int W = 16;
    localparam int C = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_word = '0;
    logic         in_mode = 1'b0;
    logic         det_reset, det_x, det_m, det_z;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [C-1:0] match_cnt;
    logic [W-1:0] match_map;
    logic         busy;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic chk_en = 1'b0;
    int last_hs = -1;

    seq_detect_scheduler #(.WORD_W(W), .CNT_W(C)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_mode(in_mode), .det_reset(det_reset), .det_x(det_x),
        .det_m(det_m), .det_z(det_z), .out_valid(out_valid), .out_ready(out_ready),
        .match_cnt(match_cnt), .match_map(match_map), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Detector: remembers the bits received since its last clear.
    logic [5:0] hist = '0;
    int         dcnt = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            dcnt <= 0;
        end else if (det_reset) begin
            hist <= '0;
            dcnt <= 0;
        end else begin
            hist <= {hist[4:0], det_x};
            dcnt <= (dcnt < 6) ? dcnt + 1 : 6;
        end
    end
    assign det_z = det_m ? ((dcnt >= 5) && ({hist[4:0], det_x} == 6'b010110))
                         : ((dcnt >= 6) && (hist == 6'b010110));

    // Expected match map of a word: every 6-bit window of the stream equal to 010110.
    function automatic logic [W-1:0] scan_map(input logic [W-1:0] w);
        logic [W-1:0] m;
        logic [5:0]   win;
        m = '0;
        for (int k = 5; k < W; k++) begin
            for (int j = 0; j < 6; j++) win[5-j] = w[W-1-(k-5+j)];
            if (win == 6'b010110) m[W-1-k] = 1'b1;
        end
        return m;
    endfunction

    // Timeline model: p = clocks since the accepting edge, -1 when idle.
    int           p = -1;
    logic         m_mode = 1'b0;
    logic         m_dm = 1'b0;
    logic [W-1:0] m_word = '0;

    function automatic int done_at(input logic mode);
        return mode ? W + 1 : W + 2;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p    <= -1;
            m_dm <= 1'b0;
        end else if (p < 0) begin
            if (in_valid) begin
                p      <= 0;
                m_word <= in_word;
                m_mode <= in_mode;
                m_dm   <= in_mode;
            end
        end else if (p >= done_at(m_mode)) begin
            if (out_ready) p <= -1;
        end else begin
            p <= p + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [5:0]   e_ctl;
        logic         e_ov;
        logic [W-1:0] e_map;
        if (chk_en && !reset) begin
            e_ov  = (p >= 0) && (p >= done_at(m_mode));
            e_ctl = {p < 0, p >= 0, e_ov, p == 0,
                     ((p >= 1) && (p <= W)) ? m_word[W-p] : 1'b0, m_dm};
            check("ctl{rdy,busy,ov,drst,x,m}",
                  {26'd0, in_ready, busy, out_valid, det_reset, det_x, det_m}, {26'd0, e_ctl});
            if (e_ov) begin
                e_map = scan_map(m_word);
                check("result{cnt,map}", {11'd0, match_cnt, match_map},
                      {11'd0, C'($countones(e_map)), e_map});
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the output handshake.
    task automatic do_word(input logic [W-1:0] w, input logic m, input logic [W-1:0] emap,
                           input int ecnt, input int elat, input int stall,
                           input logic [W-1:0] nw, input logic nm, input bit gap_chk);
        bit ok;
        int t_acc;
        in_word = w; in_mode = m; in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        check("accept_seen", {31'd0, ok}, 32'd1);
        if (!ok) return;
        @(posedge clk); #1;
        t_acc = cyc;
        in_valid = 1'b0;
        if (gap_chk) check("accept_gap_after_hs", t_acc - last_hs, 32'd1);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        check("out_valid_seen", {31'd0, ok}, 32'd1);
        if (!ok) return;
        check("latency", cyc - t_acc, elat);
        check("match_map", {16'd0, match_map}, {16'd0, emap});
        check("match_cnt", {27'd0, match_cnt}, ecnt);
        $display("word=%h mode=%0d map=%h cnt=%0d latency=%0d", w, m, match_map, match_cnt,
                 cyc - t_acc);
        if (stall > 0) begin
            in_word = nw; in_mode = nm; in_valid = 1'b1;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                check("stall_map", {16'd0, match_map}, {16'd0, emap});
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        last_hs = cyc;
        out_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Word-scan model pinned against hand-computed maps.
        check("model_5AC6", {16'd0, scan_map(16'h5AC6)}, 32'h0420);
        check("model_56B1", {16'd0, scan_map(16'h56B1)}, 32'h0108);
        check("model_0000", {16'd0, scan_map(16'h0000)}, 32'h0000);
        check("model_FFFF", {16'd0, scan_map(16'hFFFF)}, 32'h0000);

        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_outs{busy,ov,drst,x,m}", {27'd0, busy, out_valid, det_reset, det_x, det_m}, 32'd0);
        check("rst_result", {11'd0, match_cnt, match_map}, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset while shifting stream bit 7.
        in_word = 16'h5AC6; in_mode = 1'b1; in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (p == 8) begin ok = 1; break; end
        end
        check("reach_idx7", {31'd0, ok}, 32'd1);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_outs{busy,ov,drst,x,m}", {27'd0, busy, out_valid, det_reset, det_x, det_m}, 32'd0);
        $display("reset mid-word: in_ready=%0d out_valid=%0d det_x=%0d", in_ready, out_valid, det_x);
        @(posedge clk); #2;
        reset = 1'b0;

        do_word(16'h5AC6, 1'b0, 16'h0420, 2, 18, 0, '0, 1'b0, 1'b0);
        do_word(16'h5AC6, 1'b1, 16'h0420, 2, 17, 0, '0, 1'b0, 1'b0);
        do_word(16'h0000, 1'b1, 16'h0000, 0, 17, 0, '0, 1'b0, 1'b0);
        do_word(16'h0000, 1'b0, 16'h0000, 0, 18, 0, '0, 1'b0, 1'b0);
        do_word(16'hFFFF, 1'b1, 16'h0000, 0, 17, 0, '0, 1'b0, 1'b0);
        do_word(16'hFFFF, 1'b0, 16'h0000, 0, 18, 0, '0, 1'b0, 1'b0);
        // Hold the result 5 cycles with the next word already offered.
        do_word(16'h5AC6, 1'b0, 16'h0420, 2, 18, 5, 16'h56B1, 1'b1, 1'b0);
        do_word(16'h56B1, 1'b1, 16'h0108, 2, 17, 0, '0, 1'b0, 1'b1);
        do_word(16'h5AC6, 1'b0, 16'h0420, 2, 18, 0, '0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
